// File: rtl/key_pkg.sv
// ============================================================================
//  Module      : key_pkg
//  Description : Shared definitions for the key_pulse_gen front-end.
//                Holds the FSM state encoding, the {up, dn} key-code
//                constants, the direction constants and a helper that maps
//                a direction onto the key code that represents it.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package key_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_HELD     = 2'd2,
    ST_RELEASE  = 2'd3
  } state_t;

  // Key code is {up_pressed, dn_pressed}
  localparam logic [1:0] KEY_NONE = 2'b00;
  localparam logic [1:0] KEY_UP   = 2'b10;
  localparam logic [1:0] KEY_DN   = 2'b01;
  localparam logic [1:0] KEY_BOTH = 2'b11;

  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DN = 1'b0;

  function automatic logic [1:0] dir_to_code(input logic dir);
    return (dir == DIR_UP) ? KEY_UP : KEY_DN;
  endfunction

endpackage : key_pkg

`default_nettype wire

// File: rtl/key_pulse_gen_sync_2ff.sv
// ============================================================================
//  Module      : sync_2ff
//  Description : Two-flop synchronizer for a single asynchronous input.
//                Both flops load RST_VAL on reset.
//  Ports       : clk_i  - destination clock
//                rst_ni - asynchronous active-low reset
//                i_d    - asynchronous input
//                o_q    - synchronized output (2 clk latency)
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_meta <= RST_VAL;
      r_sync <= RST_VAL;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule : sync_2ff

`default_nettype wire

// File: rtl/key_pulse_gen.sv
// ============================================================================
//  Module      : key_pulse_gen
//  Description : Turns two bouncing active-low push-buttons (UP, DOWN) into a
//                single-cycle count-enable pulse plus a direction level.
//                Optional auto-repeat while a key is held, enabled by
//                defining the macro KEY_PULSE_GEN_AUTO_REPEAT_EN.
//  Ports       : clk_i     - system clock
//                rst_ni    - asynchronous active-low reset
//                key_up_ni - raw UP button, low = pressed, asynchronous
//                key_dn_ni - raw DOWN button, low = pressed, asynchronous
//                ena_o     - single-cycle count-enable pulse
//                updown_o  - direction (1 = up, 0 = down), held between pulses
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module key_pulse_gen
  import key_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned REPEAT_DELAY    = 25000000,
  parameter int unsigned REPEAT_PERIOD   = 5000000
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic key_up_ni,
  input  logic key_dn_ni,
  output logic ena_o,
  output logic updown_o
);

  // Elaboration-time parameter sanity checks. A repeat interval below 2
  // would produce back-to-back enables.
  generate
    if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
      $error("DEBOUNCE_CYCLES must be at least 2");
    end
    if (REPEAT_DELAY < 2 || REPEAT_PERIOD < 2) begin : g_bad_repeat
      $error("REPEAT_DELAY and REPEAT_PERIOD must be at least 2");
    end
  endgenerate

`ifdef KEY_PULSE_GEN_AUTO_REPEAT_EN
  localparam int unsigned CNT_MAX_A = (DEBOUNCE_CYCLES > REPEAT_DELAY) ? DEBOUNCE_CYCLES : REPEAT_DELAY;
  localparam int unsigned CNT_MAX   = (CNT_MAX_A > REPEAT_PERIOD) ? CNT_MAX_A : REPEAT_PERIOD;
`else
  localparam int unsigned CNT_MAX   = DEBOUNCE_CYCLES;
`endif
  localparam int CNT_W = $clog2(CNT_MAX);

  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  // --------------------------------------------------------------------------
  // Synchronizers (reset to released) and key-code formation
  // --------------------------------------------------------------------------
  logic       w_up_sync;
  logic       w_dn_sync;
  logic [1:0] w_code;
  logic [1:0] w_dir_code;

  sync_2ff #(.RST_VAL(1'b1)) u_sync_up (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .i_d    (key_up_ni),
    .o_q    (w_up_sync)
  );

  sync_2ff #(.RST_VAL(1'b1)) u_sync_dn (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .i_d    (key_dn_ni),
    .o_q    (w_dn_sync)
  );

  assign w_code = {~w_up_sync, ~w_dn_sync};

  // --------------------------------------------------------------------------
  // FSM
  // --------------------------------------------------------------------------
  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt,   w_cnt_nxt;
  logic             r_dir,   w_dir_nxt;
  logic             r_ena,   w_ena_nxt;
  logic             r_updown, w_updown_nxt;

`ifdef KEY_PULSE_GEN_AUTO_REPEAT_EN
  // r_rep_run: 0 while waiting for the first repeat (REPEAT_DELAY),
  //            1 once repeating (REPEAT_PERIOD).
  logic [CNT_W-1:0] r_rep, w_rep_nxt;
  logic             r_rep_run, w_rep_run_nxt;
  logic [CNT_W-1:0] w_rep_last;

  assign w_rep_last = r_rep_run ? CNT_W'(REPEAT_PERIOD - 1) : CNT_W'(REPEAT_DELAY - 1);
`endif

  assign w_dir_code = dir_to_code(r_dir);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_dir     <= DIR_UP;
      r_ena     <= 1'b0;
      r_updown  <= DIR_UP;
`ifdef KEY_PULSE_GEN_AUTO_REPEAT_EN
      r_rep     <= '0;
      r_rep_run <= 1'b0;
`endif
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_dir     <= w_dir_nxt;
      r_ena     <= w_ena_nxt;
      r_updown  <= w_updown_nxt;
`ifdef KEY_PULSE_GEN_AUTO_REPEAT_EN
      r_rep     <= w_rep_nxt;
      r_rep_run <= w_rep_run_nxt;
`endif
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_dir_nxt     = r_dir;
    w_ena_nxt     = 1'b0;
    w_updown_nxt  = r_updown;
`ifdef KEY_PULSE_GEN_AUTO_REPEAT_EN
    w_rep_nxt     = r_rep;
    w_rep_run_nxt = r_rep_run;
`endif

    unique case (r_state)
      ST_IDLE: begin
        if (w_code == KEY_UP || w_code == KEY_DN) begin
          w_dir_nxt   = (w_code == KEY_UP) ? DIR_UP : DIR_DN;
          w_cnt_nxt   = '0;
          w_state_nxt = ST_DEBOUNCE;
        end
      end

      ST_DEBOUNCE: begin
        if (w_code != w_dir_code) begin
          w_cnt_nxt   = '0;
          w_state_nxt = ST_IDLE;
        end else if (r_cnt == DB_LAST) begin
          w_cnt_nxt     = '0;
          w_state_nxt   = ST_HELD;
          w_ena_nxt     = 1'b1;
          w_updown_nxt  = r_dir;
`ifdef KEY_PULSE_GEN_AUTO_REPEAT_EN
          w_rep_nxt     = '0;
          w_rep_run_nxt = 1'b0;
`endif
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end

      ST_HELD: begin
        // Both-keys and opposite-key codes are ignored here (timer holds).
        if (w_code == KEY_NONE) begin
          w_cnt_nxt     = '0;
          w_state_nxt   = ST_RELEASE;
`ifdef KEY_PULSE_GEN_AUTO_REPEAT_EN
          w_rep_nxt     = '0;
          w_rep_run_nxt = 1'b0;
        end else if (w_code == w_dir_code) begin
          if (r_rep == w_rep_last) begin
            w_ena_nxt     = 1'b1;
            w_updown_nxt  = r_dir;
            w_rep_nxt     = '0;
            w_rep_run_nxt = 1'b1;
          end else begin
            w_rep_nxt = r_rep + 1'b1;
          end
`endif
        end
      end

      ST_RELEASE: begin
        // A press here is release bounce: back to HELD, repeat timer from 0
        // (it was cleared on leaving HELD).
        if (w_code != KEY_NONE) begin
          w_cnt_nxt   = '0;
          w_state_nxt = ST_HELD;
        end else if (r_cnt == DB_LAST) begin
          w_cnt_nxt   = '0;
          w_state_nxt = ST_IDLE;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end

      default: begin
        w_cnt_nxt   = '0;
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign ena_o    = r_ena;
  assign updown_o = r_updown;

endmodule : key_pulse_gen

`default_nettype wire

// File: tb/tb_key_pulse_gen.sv
// ============================================================================
//  Module      : tb_key_pulse_gen
//  Description : Self-checking bench for key_pulse_gen. Expected pulses
//                (cycle, direction) are queued when a key is driven and
//                matched against every ena_o pulse the DUT produces.
//                Works with and without KEY_PULSE_GEN_AUTO_REPEAT_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_key_pulse_gen;
  import key_pkg::*;

  localparam int DB = 4;
  localparam int RD = 10;
  localparam int RP = 3;

  logic clk      = 1'b0;
  logic rst_n    = 1'b0;
  logic key_up_n = 1'b1;
  logic key_dn_n = 1'b1;
  logic ena;
  logic updown;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  typedef struct {
    int   edge_no;
    logic dir;
  } exp_t;

  exp_t q[$];
  logic prev_ena = 1'b0;

  key_pulse_gen #(
    .DEBOUNCE_CYCLES (DB),
    .REPEAT_DELAY    (RD),
    .REPEAT_PERIOD   (RP)
  ) dut (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .key_up_ni (key_up_n),
    .key_dn_ni (key_dn_n),
    .ena_o     (ena),
    .updown_o  (updown)
  );

  always #5 clk = ~clk;

  // cyc equals the number of the most recent rising edge
  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed=%0d expected=%0d (cycle %0d)", tag, obs, expv, cyc);
    end
  endtask

  task automatic push(input int edge_no, input logic dir);
    exp_t e;
    e.edge_no = edge_no;
    e.dir     = dir;
    q.push_back(e);
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic idle(input int k);
    repeat (k) @(negedge clk);
  endtask

  // Scoreboard side: every pulse must match the oldest expected entry.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && ena) begin
      check("no_back_to_back", prev_ena, 0);
      check("pulse_expected", q.size() != 0, 1);
      if (q.size() != 0) begin
        e = q.pop_front();
        check("pulse_cycle", cyc, e.edge_no);
        check("pulse_dir", updown, e.dir);
      end
    end
    prev_ena = rst_n ? ena : 1'b0;
  end

  initial begin
    int n;
    int m;

    // ---- reset state
    idle(3);
    #1;
    check("reset_ena", ena, 0);
    check("reset_updown", updown, 1);
    check("reset_state", 32'(dut.r_state), 32'(ST_IDLE));
    idle(1);
    rst_n = 1'b1;
    idle(3);

    // ---- S1: clean UP press held 20 cycles
    n = cyc;
    key_up_n = 1'b0;
    push(n + 7, DIR_UP);
`ifdef KEY_PULSE_GEN_AUTO_REPEAT_EN
    push(n + 17, DIR_UP);
    push(n + 20, DIR_UP);
`endif
    wait_until(n + 20);
    key_up_n = 1'b1;
    idle(12);
    check("s1_all_pulses_seen", q.size(), 0);

    // ---- S3: both keys for 50 cycles
    n = cyc;
    key_up_n = 1'b0;
    key_dn_n = 1'b0;
    wait_until(n + 50);
    key_up_n = 1'b1;
    key_dn_n = 1'b1;
    idle(12);
    check("s3_no_pulse", q.size(), 0);
    check("s3_updown_kept", updown, 1);

    // ---- S4: UP held, DOWN added for 10 cycles
    n = cyc;
    key_up_n = 1'b0;
    push(n + 7, DIR_UP);
`ifdef KEY_PULSE_GEN_AUTO_REPEAT_EN
    push(n + 27, DIR_UP);
    push(n + 30, DIR_UP);
`endif
    wait_until(n + 9);
    key_dn_n = 1'b0;
    wait_until(n + 19);
    check("s4_updown_during_both", updown, 1);
    key_dn_n = 1'b1;
    wait_until(n + 29);
    key_up_n = 1'b1;
    idle(12);
    check("s4_all_pulses_seen", q.size(), 0);
    check("s4_updown", updown, 1);

    // ---- S5: release bounce after accepted press
    n = cyc;
    key_up_n = 1'b0;
    push(n + 7, DIR_UP);
    wait_until(n + 10);
    key_up_n = 1'b1;
    wait_until(n + 12);
    key_up_n = 1'b0;
    wait_until(n + 13);
    check("s5_in_release", 32'(dut.r_state), 32'(ST_RELEASE));
    wait_until(n + 16);
    check("s5_back_to_held", 32'(dut.r_state), 32'(ST_HELD));
    wait_until(n + 20);
    key_up_n = 1'b1;
    idle(12);
    check("s5_all_pulses_seen", q.size(), 0);

    // ---- S2: DOWN bouncing, then steady
    n = cyc;
    key_dn_n = 1'b0;
    wait_until(n + 2);
    key_dn_n = 1'b1;
    wait_until(n + 3);
    key_dn_n = 1'b0;
    push(n + 10, DIR_DN);
    wait_until(n + 12);
    key_dn_n = 1'b1;
    idle(12);
    check("s2_all_pulses_seen", q.size(), 0);
    check("s2_updown_down", updown, 0);

    // ---- S6: reset mid-debounce (count 2), then re-debounce
    n = cyc;
    key_up_n = 1'b0;
    wait_until(n + 5);
    check("s6_cnt_before_reset", 32'(dut.r_cnt), 2);
    rst_n = 1'b0;
    #1;
    check("s6_reset_ena", ena, 0);
    check("s6_reset_updown", updown, 1);
    idle(2);
    m = cyc;
    rst_n = 1'b1;
    push(m + 7, DIR_UP);
    wait_until(m + 9);
    key_up_n = 1'b1;
    idle(12);
    check("s6_all_pulses_seen", q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_key_pulse_gen

`default_nettype wire
